fpu_rsp_tracker: RTL

Responder-side front end for the `fpu` core. It accepts operation requests over a valid/ready handshake and launches them into the fixed-latency FPU pipeline. It tracks each operation's tag through that latency, then captures the FPU result and exception flags into a response FIFO drained by a second valid/ready handshake. Credit-based flow control ensures no result is ever dropped while the consumer back-pressures.

---
 rtl/fpu_rsp_tracker_if.sv | 41 ++++
 rtl/fpu_rsp_tracker.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/fpu_rsp_tracker_if.sv
// Request, FPU launch/return and response bundle for fpu_rsp_tracker.
// The slave modport is the tracker's view; master is the view of the environment around it.
interface fpu_rsp_tracker_if #(
  parameter int TAG_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [1:0]       req_rmode;
  logic [31:0]      req_opa;
  logic [31:0]      req_opb;
  logic [TAG_W-1:0] req_tag;

  logic [2:0]       fpu_op;
  logic [1:0]       fpu_rmode;
  logic [31:0]      fpu_opa;
  logic [31:0]      fpu_opb;
  logic [31:0]      fpu_out;
  logic [7:0]       fpu_flags;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_data;
  logic [7:0]       rsp_flags;
  logic [TAG_W-1:0] rsp_tag;
  logic [2:0]       rsp_op;

  modport slave (
    input  req_valid, req_op, req_rmode, req_opa, req_opb, req_tag,
    input  fpu_out, fpu_flags, rsp_ready,
    output req_ready, fpu_op, fpu_rmode, fpu_opa, fpu_opb,
    output rsp_valid, rsp_data, rsp_flags, rsp_tag, rsp_op
  );

  modport master (
    output req_valid, req_op, req_rmode, req_opa, req_opb, req_tag,
    output fpu_out, fpu_flags, rsp_ready,
    input  req_ready, fpu_op, fpu_rmode, fpu_opa, fpu_opb,
    input  rsp_valid, rsp_data, rsp_flags, rsp_tag, rsp_op
  );
endinterface

// File: rtl/fpu_rsp_tracker.sv
// Credit-controlled front end for a fixed-latency FPU: launches ops, tracks tags, queues results.
// Optional FPU_RSP_ERRCNT_EN adds a saturating 16-bit count of popped responses with error flags.
module fpu_rsp_tracker #(
  parameter int FPU_LATENCY = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int TAG_W       = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  fpu_rsp_tracker_if.slave bus
`ifdef FPU_RSP_ERRCNT_EN
  ,
  output logic [15:0]      err_count
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 32 + 8 + TAG_W + 3;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic                            req_ready_c;
  logic                            accept;
  logic                            pop;
  logic [CNT_W-1:0]                outstanding_q, outstanding_d;

  logic [2:0]                      fpu_op_q, fpu_op_d;
  logic [1:0]                      fpu_rmode_q, fpu_rmode_d;
  logic [31:0]                     fpu_opa_q, fpu_opa_d;
  logic [31:0]                     fpu_opb_q, fpu_opb_d;

  logic [FPU_LATENCY:0]            pipe_valid_q, pipe_valid_d;
  logic [FPU_LATENCY:0][TAG_W-1:0] pipe_tag_q, pipe_tag_d;
  logic [FPU_LATENCY:0][2:0]       pipe_op_q, pipe_op_d;

  logic                            wr_en;
  logic [ENT_W-1:0]                wr_data;
  logic [ENT_W-1:0]                mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]                wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]                rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]                fifo_cnt_q, fifo_cnt_d;

  logic                            rsp_valid_q, rsp_valid_d;
  logic [ENT_W-1:0]                rsp_ent_q, rsp_ent_d;
  logic [31:0]                     rsp_data_w;
  logic [7:0]                      rsp_flags_w;
  logic [TAG_W-1:0]                rsp_tag_w;
  logic [2:0]                      rsp_op_w;

  // Credit comes from registered state only, so a pop frees a slot one cycle later.
  assign req_ready_c = reset_n && (outstanding_q < DEPTH_C);

  always_comb begin
    accept        = bus.req_valid && req_ready_c;
    pop           = rsp_valid_q && bus.rsp_ready;
    outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(pop);

    fpu_op_d    = fpu_op_q;
    fpu_rmode_d = fpu_rmode_q;
    fpu_opa_d   = fpu_opa_q;
    fpu_opb_d   = fpu_opb_q;
    if (accept) begin
      fpu_op_d    = bus.req_op;
      fpu_rmode_d = bus.req_rmode;
      fpu_opa_d   = bus.req_opa;
      fpu_opb_d   = bus.req_opb;
    end

    pipe_valid_d = {pipe_valid_q[FPU_LATENCY-1:0], accept};
    pipe_tag_d   = {pipe_tag_q[FPU_LATENCY-1:0], bus.req_tag};
    pipe_op_d    = {pipe_op_q[FPU_LATENCY-1:0], bus.req_op};

    wr_en   = pipe_valid_q[FPU_LATENCY];
    wr_data = {bus.fpu_out, bus.fpu_flags, pipe_tag_q[FPU_LATENCY], pipe_op_q[FPU_LATENCY]};

    wr_ptr_d   = wr_ptr_q + PTR_W'(wr_en);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    fifo_cnt_d = fifo_cnt_q + CNT_W'(wr_en) - CNT_W'(pop);

    // The response register mirrors the post-edge head; a write into an emptying FIFO bypasses memory.
    rsp_valid_d = (fifo_cnt_d != '0);
    rsp_ent_d   = rsp_ent_q;
    if (wr_en && (fifo_cnt_q == CNT_W'(pop))) begin
      rsp_ent_d = wr_data;
    end else if (rsp_valid_d) begin
      rsp_ent_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outstanding_q <= '0;
      fpu_op_q      <= '0;
      fpu_rmode_q   <= '0;
      fpu_opa_q     <= '0;
      fpu_opb_q     <= '0;
      pipe_valid_q  <= '0;
      pipe_tag_q    <= '0;
      pipe_op_q     <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fifo_cnt_q    <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_ent_q     <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      fpu_op_q      <= fpu_op_d;
      fpu_rmode_q   <= fpu_rmode_d;
      fpu_opa_q     <= fpu_opa_d;
      fpu_opb_q     <= fpu_opb_d;
      pipe_valid_q  <= pipe_valid_d;
      pipe_tag_q    <= pipe_tag_d;
      pipe_op_q     <= pipe_op_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fifo_cnt_q    <= fifo_cnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_ent_q     <= rsp_ent_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Credit bounds occupancy, so a write into a full FIFO without a same-cycle pop is a bug.
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(wr_en && (fifo_cnt_q == DEPTH_C) && !pop));

  assign {rsp_data_w, rsp_flags_w, rsp_tag_w, rsp_op_w} = rsp_ent_q;

  assign bus.req_ready = req_ready_c;
  assign bus.fpu_op    = fpu_op_q;
  assign bus.fpu_rmode = fpu_rmode_q;
  assign bus.fpu_opa   = fpu_opa_q;
  assign bus.fpu_opb   = fpu_opb_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_w;
  assign bus.rsp_flags = rsp_flags_w;
  assign bus.rsp_tag   = rsp_tag_w;
  assign bus.rsp_op    = rsp_op_w;

`ifdef FPU_RSP_ERRCNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;
  logic        err_hit;

  // Error flags: snan, qnan, overflow, underflow, div_by_zero.
  always_comb begin
    err_hit   = pop && ((rsp_flags_w & 8'h6D) != 8'h00);
    err_cnt_d = err_cnt_q;
    if (err_hit && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`endif

endmodule
